tile_spawner: RTL
=================

Name: tile_spawner

Overview:
- Consumes the board word (16 cells × 4-bit log2 tile codes, cell i at bits [4i+3:4i]) and the 16-bit occupancy mask produced by the occupancy judge stage.
- On request, picks a pseudo-random empty cell and writes a new tile (code 1 = "2", optionally code 2 = "4") into it.
- Returns the updated board to the game-state register. Sits directly downstream of the occupancy judge, after each move's merge/shift step.

Parameters:
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001 internally.
- FOUR_THRESH, 4, a "4" tile spawns when lfsr[7:4] < FOUR_THRESH (4/16 ≈ 25%); only used with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- spawn_req  in  1  one-cycle request pulse; sampled only in IDLE
- board_in  in  64  current board, cell i at [4i+3:4i]
- occ  in  16  occupancy mask from judge, bit i = 1 when cell i is non-zero
- board_out  out  64  board with new tile inserted; held until the next done
- cell_idx  out  4  index of the cell written by the last spawn
- done  out  1  one-cycle pulse; board_out/cell_idx are valid and updated this cycle
- no_space  out  1  one-cycle pulse; request rejected because occ == 16'hFFFF
- busy  out  1  high while in SCAN

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; board_out=0; cell_idx=0; done=0; no_space=0; busy=0.
  - lfsr=SEED (or 1 if SEED==0); internal latches cleared.
  - Reset mid-SCAN abandons the spawn with no done pulse.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1; feedback = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Shift left with feedback into bit 0; advances every cycle after reset, free-running in every state.
  - Never reaches 0.
- State machine, two states: IDLE and SCAN.
- IDLE:
  - done and no_space default to 0 every cycle unless set below.
  - spawn_req=1 and occ==16'hFFFF: no_space<=1; stay IDLE; board_out and cell_idx unchanged.
  - spawn_req=1 otherwise:
    - board_q<=board_in; occ_q<=occ; idx<=lfsr[3:0]; val<=chosen code (see Optional Feature).
    - state<=SCAN.
- SCAN:
  - busy=1 for every cycle in SCAN.
  - Each cycle tests occ_q[idx].
  - If 0: board_out<=board_q with nibble idx replaced by val; cell_idx<=idx; done<=1; state<=IDLE.
  - If 1: idx<=idx+1, wrapping modulo 16 (15→0).
- Latency:
  - done asserts k+1 cycles after the edge that samples spawn_req, where k = number of occupied cells skipped (0..15).
  - Worst case is 16 cycles.
- spawn_req while busy is ignored (not queued).
- spawn_req in the cycle done is high is accepted: state is IDLE again.
- Occupancy source:
  - The scan uses only the latched occ_q, never board contents.
  - Changes to occ/board_in after acceptance have no effect on the spawn in flight.
  - Cells other than idx pass through unchanged from board_q.

Optional Feature:
- Macro: TILE_SPAWN_FOUR_EN.
- Defined: val = 4'd2 when lfsr[7:4] < FOUR_THRESH, else 4'd1, using the lfsr value in the accepting cycle.
- Undefined: val = 4'd1 always; FOUR_THRESH unused; lfsr[7:4] ignored.

Test Plan:
- Reset then idle: rst pulsed mid-SCAN -> all outputs 0 immediately (async), no done, busy=0; next request behaves normally.
- Full board: occ=16'hFFFF, spawn_req pulse -> no_space=1 for exactly one cycle the next cycle; done stays 0; board_out unchanged.
- Single hole: board_in=64'h1111_1111_1111_1110, occ=16'hFFFE, macro undefined -> done within 1..16 cycles; cell_idx=0; board_out=64'h1111_1111_1111_1111.
- Empty board with SEED=16'hACE1, macro undefined -> done exactly 1 cycle after acceptance; cell_idx = lfsr[3:0] at acceptance (bench model); the single written nibble = 1.
- Wrap-around: only cell 0 empty, lfsr[3:0] forced to 15 via SEED choice -> scan visits 15 then 0; done 2 cycles after acceptance; cell_idx=0.
- Busy/back-to-back: spawn_req repeated during SCAN -> ignored, one done only; request in the done cycle -> second spawn accepted. With TILE_SPAWN_FOUR_EN over 1000 empty-board spawns -> every written nibble is 1 or 2, and the count of 2 is near 25%.

Source files
------------

// File: rtl/tile_spawner.sv
// rtl/tile_spawner.sv - places a new tile in a pseudo-random empty cell of the board
// Optional "4" tiles enabled by defining TILE_SPAWN_FOUR_EN.
module tile_spawner #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned FOUR_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn_req,
  input  logic [63:0] board_in,
  input  logic [15:0] occ,
  output logic [63:0] board_out,
  output logic [3:0]  cell_idx,
  output logic        done,
  output logic        no_space,
  output logic        busy
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] board_q, board_ins;
  logic [15:0] occ_q;
  logic [3:0]  idx_q, val_q, new_val;
  logic [63:0] board_out_q;
  logic [3:0]  cell_idx_q;
  logic        done_q, no_space_q;
  logic        full, slot_free;

  assign full      = (occ == 16'hFFFF);
  assign slot_free = ~occ_q[idx_q];
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef TILE_SPAWN_FOUR_EN
  assign new_val = (32'(lfsr_q[7:4]) < FOUR_THRESH) ? 4'd2 : 4'd1;
`else
  assign new_val = 4'd1;
`endif

  always_comb begin
    board_ins = board_q;
    board_ins[{idx_q, 2'b00} +: 4] = val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (spawn_req && !full) state_d = SCAN;
      SCAN:    if (slot_free)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
  end

  // LFSR free-runs in every state; done/no_space are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= SEED_EFF;
      board_q     <= '0;
      occ_q       <= '0;
      idx_q       <= '0;
      val_q       <= '0;
      board_out_q <= '0;
      cell_idx_q  <= '0;
      done_q      <= 1'b0;
      no_space_q  <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      done_q     <= 1'b0;
      no_space_q <= 1'b0;
      if (state_q == IDLE) begin
        if (spawn_req && full) begin
          no_space_q <= 1'b1;
        end else if (spawn_req) begin
          board_q <= board_in;
          occ_q   <= occ;
          idx_q   <= lfsr_q[3:0];
          val_q   <= new_val;
        end
      end else if (slot_free) begin
        board_out_q <= board_ins;
        cell_idx_q  <= idx_q;
        done_q      <= 1'b1;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  assign board_out = board_out_q;
  assign cell_idx  = cell_idx_q;
  assign done      = done_q;
  assign no_space  = no_space_q;

endmodule
